// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes datapath.
//   AES_STATE_W / AES_BYTES : state width in bits / bytes
//   aes_state_t / aes_byte_t : state and byte types
//   aes_fsm_e                : sequencer state encoding
//   byte_lsb()               : bit offset of byte i (byte 0 is the MSB byte)
//   shift_rows_src()         : ShiftRows source byte index for output byte i
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [7:0]             aes_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    // Byte i lives at state[127-8i -: 8], i.e. its LSB is at 8*(15-i).
    function automatic int byte_lsb(input int idx);
        return 8 * (AES_BYTES - 1 - idx);
    endfunction

    // Column-major layout: row = i%4, col = i/4.
    // Output (r,c) takes input (r,(c+r)%4).
    function automatic int shift_rows_src(input int idx);
        int r;
        int c;
        r = idx % 4;
        c = idx / 4;
        return 4 * ((c + r) % 4) + r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
//   addr_i : input byte
//   data_o : S-box image of addr_i
module aes_sbox (
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    // Entry 0x00 sits in the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a starts at bit 8*(255-a) = {~a, 3'b000}.
    logic [10:0] lsb;

    assign lsb    = {~addr_i, 3'b000};
    assign data_o = SBOX_TABLE[lsb +: 8];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes: substitutes LANES bytes per cycle of a 128-bit state.
// Optional macro AES_SUB_BYTES_SHIFT_ROWS_EN adds ShiftRows as fixed output wiring.
//   clk, rst_n           : clock, asynchronous active-low reset
//   abort                : synchronous flush, highest priority
//   in_valid/in_ready    : input handshake, in_state captured on transfer
//   out_valid/out_ready  : output handshake, out_state held until taken
//   busy                 : high while a job is in RUN or DONE
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NUM_STEPS = AES_BYTES / LANES;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    aes_fsm_e          fsm_q;
    logic [STEP_W-1:0] step_q;
    aes_state_t        work_q;
    aes_state_t        work_d;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    logic [6:0] lane_lsb [LANES];
    aes_byte_t  lane_in  [LANES];
    aes_byte_t  lane_out [LANES];

    // Lane l handles byte step*LANES+l; byte index b has LSB 8*(15-b) = {~b, 3'b000}.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] idx;
        assign idx         = 4'(int'(step_q) * LANES + l);
        assign lane_lsb[l] = {~idx, 3'b000};
        assign lane_in[l]  = work_q[lane_lsb[l] +: 8];

        aes_sbox u_sbox (
            .addr_i (lane_in[l]),
            .data_o (lane_out[l])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[lane_lsb[l] +: 8] = lane_out[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            step_q      <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else if (abort) begin
            fsm_q       <= ST_IDLE;
            step_q      <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= in_state;
                        step_q     <= '0;
                        fsm_q      <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    work_q <= work_d;
                    if (step_q == LAST_STEP) begin
                        step_q      <= '0;
                        fsm_q       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE (not accepting) guarantees a gap cycle between jobs.
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    step_q      <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
    for (genvar i = 0; i < AES_BYTES; i++) begin : g_out
        localparam int SRC = shift_rows_src(i);
        assign out_state[byte_lsb(i) +: 8] = work_q[byte_lsb(SRC) +: 8];
    end
`else
    assign out_state = work_q;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
module tb_aes_sub_bytes_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         abort;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_state;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [127:0] VEC      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP_ZERO = {16{8'h63}};
    localparam logic [127:0] EXP_FF   = {16{8'h16}};
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
    localparam logic [127:0] EXP_VEC  = 128'h63fcac161bee28c3c4c193f54b8233ea;
`else
    localparam logic [127:0] EXP_VEC  = 128'h638293c31bfc33f5c4eeacea4bc12816;
`endif

    aes_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    // One instance per legal LANES value (1<<g), fed the same stimulus.
    logic         lv [5];
    logic         lr [5];
    logic         lb [5];
    logic [127:0] ls [5];

    for (genvar g = 0; g < 5; g++) begin : g_lanes
        aes_sub_bytes_seq #(.LANES(1 << g)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .abort     (abort),
            .in_valid  (in_valid),
            .in_ready  (lr[g]),
            .in_state  (in_state),
            .out_valid (lv[g]),
            .out_ready (out_ready),
            .out_state (ls[g]),
            .busy      (lb[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        #3;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL reset_out_state got %h want 0", out_state); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_zero();
        in_state = '0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = 128'hffeeddccbbaa99887766554433221100;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy got %b want 1", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready got %b want 0", in_ready); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (out_valid !== (k == 4)) begin
                n_bad++; $display("FAIL zero_latency cycle %0d got %b want %b", k, out_valid, (k == 4));
            end
        end
        n_vec++; if (out_state !== EXP_ZERO) begin n_bad++; $display("FAIL zero_result got %h want %h", out_state, EXP_ZERO); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_pop_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_pop_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_hold_vector();
        in_state = VEC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = 128'hdeadbeefcafef00d0123456789abcdef;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid cycle %0d got %b want 1", i, out_valid); end
            n_vec++; if (out_state !== EXP_VEC) begin n_bad++; $display("FAIL hold_state cycle %0d got %h want %h", i, out_state, EXP_VEC); end
            n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready cycle %0d got %b want 0", i, in_ready); end
            tick();
        end
        // Output handshake with a new input offered at the same edge: must not accept.
        out_ready = 1'b1; in_valid = 1'b1; in_state = '0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL release_no_accept busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        in_state = {16{8'hff}}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL abort_clear got %h want 0", out_state); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_no_valid cycle %0d got %b want 0", i, out_valid); end
        end
        // abort beats an input handshake in the same cycle
        abort = 1'b1; in_valid = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_vs_in busy got %b want 0", busy); end
        in_state = {16{8'hff}}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ff_valid got %b want 1", out_valid); end
        n_vec++; if (out_state !== EXP_FF) begin n_bad++; $display("FAIL ff_result got %h want %h", out_state, EXP_FF); end
        // abort beats the output handshake in DONE
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_done_valid got %b want 0", out_valid); end
        n_vec++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL abort_done_clear got %h want 0", out_state); end
    endtask

    task automatic test_async_reset();
        in_state = VEC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid got %b want 0", out_valid); end
        n_vec++; if (out_state !== 128'h0) begin n_bad++; $display("FAIL async_rst_state got %h want 0", out_state); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_no_partial cycle %0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_lanes(input logic [127:0] vec, input logic [127:0] exp);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b1;
        in_state = vec; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = ~vec;
        for (int k = 1; k <= 16; k++) begin
            tick();
            for (int g = 0; g < 5; g++) begin
                n_vec++;
                if (lv[g] !== (k == (16 >> g))) begin
                    n_bad++; $display("FAIL lanes%0d_valid cycle %0d got %b want %b", 1 << g, k, lv[g], (k == (16 >> g)));
                end
                if (k == (16 >> g)) begin
                    n_vec++;
                    if (ls[g] !== exp) begin
                        n_bad++; $display("FAIL lanes%0d_result got %h want %h", 1 << g, ls[g], exp);
                    end
                end
            end
        end
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_hold_vector();
        test_abort();
        test_async_reset();
        test_lanes(128'h0, EXP_ZERO);
        test_lanes(VEC, EXP_VEC);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
